// File: rtl/multi_cycle_adder_pkg.sv
// rtl/multi_cycle_adder_pkg.sv - shared types and sizing helpers for the multi-cycle adder
package multi_cycle_adder_pkg;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Index width; never narrower than one bit so a single-chunk build still has a counter.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_cycle_adder_chunk_adder.sv
// rtl/multi_cycle_adder_chunk_adder.sv - N-bit ripple chunk adder built from full_adder cells
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module chunk_adder
  import multi_cycle_adder_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         c_msb
);
  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout  = c[N];
  // Carry into the top bit; XOR with cout gives signed overflow.
  assign c_msb = c[N-1];
endmodule

// File: rtl/multi_cycle_adder.sv
// rtl/multi_cycle_adder.sv - add/subtract WIDTH-bit operands CHUNK bits per clock, valid/ready handshakes
// Optional zero/neg result flags under MULTI_CYCLE_ADDER_FLAGS_EN.
module multi_cycle_adder
  import multi_cycle_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
`ifdef MULTI_CYCLE_ADDER_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg
`endif
);
  localparam int NCH = nchunk(WIDTH, CHUNK);
  localparam int IW  = clog2(NCH);

  state_t            state, next_state;
  logic [WIDTH-1:0]  a_reg, b_reg;
  logic              carry;
  logic [IW-1:0]     idx;
  logic [CHUNK-1:0]  a_chunk, b_chunk, s_chunk;
  logic              c_out, c_msb;
  logic              last;

  assign a_chunk = a_reg[idx*CHUNK +: CHUNK];
  assign b_chunk = b_reg[idx*CHUNK +: CHUNK];
  assign last    = (idx == IW'(NCH - 1));

  chunk_adder #(.N(CHUNK)) u_chunk (
    .a     (a_chunk),
    .b     (b_chunk),
    .cin   (carry),
    .s     (s_chunk),
    .cout  (c_out),
    .c_msb (c_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = ADD;
      ADD:     if (last) next_state = DONE;
      DONE:    if (out_valid && out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  // out_valid is registered, so it rises one cycle after entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state == DONE) && !(out_valid && out_ready);
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b ^ {WIDTH{sub}};
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
          end
        end
        ADD: begin
          sum[idx*CHUNK +: CHUNK] <= s_chunk;
          carry                   <= c_out;
          if (last) begin
            cout <= c_out;
            ovf  <= c_msb ^ c_out;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULTI_CYCLE_ADDER_FLAGS_EN
  logic zero_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_acc <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      zero_acc <= 1'b1;
    end else if (state == ADD) begin
      zero_acc <= zero_acc & ~|s_chunk;
    end
  end

  assign zero = zero_acc;
  assign neg  = sum[WIDTH-1];
`endif

endmodule

// File: tb/tb_multi_cycle_adder.sv
// tb/tb_multi_cycle_adder.sv - directed bench for multi_cycle_adder (32/4 and 8/8 builds)
module tb_multi_cycle_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0, in_ready;
  logic [31:0] a = '0, b = '0, sum;
  logic        cin = 1'b0, sub = 1'b0;
  logic        out_valid, out_ready = 1'b0, cout, ovf;

  logic        x_in_valid = 1'b0, x_in_ready;
  logic [7:0]  x_a = '0, x_b = '0, x_sum;
  logic        x_cin = 1'b0, x_sub = 1'b0;
  logic        x_out_valid, x_out_ready = 1'b0, x_cout, x_ovf;

`ifdef MULTI_CYCLE_ADDER_FLAGS_EN
  logic zero, neg, x_zero, x_neg;
`endif

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multi_cycle_adder #(.WIDTH(32), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
`ifdef MULTI_CYCLE_ADDER_FLAGS_EN
    , .zero(zero), .neg(neg)
`endif
  );

  multi_cycle_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x_in_ready),
    .a(x_a), .b(x_b), .cin(x_cin), .sub(x_sub), .out_valid(x_out_valid), .out_ready(x_out_ready),
    .sum(x_sum), .cout(x_cout), .ovf(x_ovf)
`ifdef MULTI_CYCLE_ADDER_FLAGS_EN
    , .zero(x_zero), .neg(x_neg)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    applied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accepts one operation on the 32-bit unit and measures edges until out_valid.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tc, input logic ts, input int exp_lat);
    int cnt;
    @(negedge clk);
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'b1; sub = ~ts;
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({tag, " latency"}, 32'(cnt), 32'(exp_lat));
  endtask

  task automatic check_res(input string tag, input logic [31:0] es, input logic ec,
                           input logic eo, input logic ez, input logic en);
    check({tag, " sum"}, sum, es);
    check({tag, " cout"}, 32'(cout), 32'(ec));
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
`ifdef MULTI_CYCLE_ADDER_FLAGS_EN
    check({tag, " zero"}, 32'(zero), 32'(ez));
    check({tag, " neg"}, 32'(neg), 32'(en));
`else
    if (ez === en) begin end
`endif
  endtask

  task automatic release_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int cnt;
    #2;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset sum", sum, 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 9);
    check_res("wrap", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    release_op("wrap");

    run_op("sub5m7", 32'd5, 32'd7, 1'b1, 1'b1, 9);
    check_res("sub5m7", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    release_op("sub5m7");

    run_op("sub7m5", 32'd7, 32'd5, 1'b0, 1'b1, 9);
    check_res("sub7m5", 32'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    release_op("sub7m5");

    run_op("posovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 9);
    check_res("posovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    release_op("posovf");

    run_op("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 9);
    check_res("negovf", 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    release_op("negovf");

    run_op("cin", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 9);
    check_res("cin", 32'h2345_678A, 1'b0, 1'b0, 1'b0, 1'b0);
    release_op("cin");

    run_op("subovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 9);
    check_res("subovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);

    // Backpressure: result must stay put while the consumer stalls.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold in_ready", 32'(in_ready), 32'd0);
      check("hold sum", sum, 32'h7FFF_FFFF);
      check("hold cout", 32'(cout), 32'd1);
      check("hold ovf", 32'(ovf), 32'd1);
    end
    release_op("hold");

    // Reset during the third ADD cycle discards the in-flight result.
    @(negedge clk);
    a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst sum", sum, 32'd0);
    check("rst cout", 32'(cout), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("postrst", 32'd1, 32'd2, 1'b0, 1'b0, 9);
    check_res("postrst", 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    release_op("postrst");

    // Single-chunk build.
    @(negedge clk);
    check("w8 in_ready", 32'(x_in_ready), 32'd1);
    x_a = 8'hF0; x_b = 8'h20; x_cin = 1'b1; x_sub = 1'b0; x_in_valid = 1'b1;
    @(posedge clk);
    #1;
    x_in_valid = 1'b0;
    x_a = 8'h00; x_b = 8'h00; x_cin = 1'b0;
    cnt = 0;
    while (!x_out_valid && cnt < 50) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("w8 latency", 32'(cnt), 32'd2);
    check("w8 sum", 32'(x_sum), 32'h11);
    check("w8 cout", 32'(x_cout), 32'd1);
    check("w8 ovf", 32'(x_ovf), 32'd0);
`ifdef MULTI_CYCLE_ADDER_FLAGS_EN
    check("w8 zero", 32'(x_zero), 32'd0);
    check("w8 neg", 32'(x_neg), 32'd0);
`endif
    x_out_ready = 1'b1;
    @(posedge clk);
    #1;
    x_out_ready = 1'b0;
    check("w8 out_valid drop", 32'(x_out_valid), 32'd0);
    check("w8 in_ready back", 32'(x_in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
